// File: rtl/fault_responder.sv
// fault_responder: response end of the fault detector. It drives power enable, derate and the detector re-arm,
// and runs bounded auto-retry with holdoff and a latched lockout. Optional trip counter: FAULT_RESP_TRIP_CNT_EN.
module fault_responder #(
    parameter int unsigned HOLDOFF_CYCLES   = 16,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned SOFTSTART_CYCLES = 4,
    parameter int unsigned STABLE_CYCLES    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               warning,
    input  logic                               fault,
    input  logic                               shutdown,
    input  logic                               ack_clear,
    output logic                               pwr_en,
    output logic                               derate,
    output logic                               det_rstn,
    output logic                               lockout,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [2:0]                         state
`ifdef FAULT_RESP_TRIP_CNT_EN
    ,
    output logic [15:0]                        trip_count
`endif
);

    localparam int unsigned RW           = $clog2(MAX_RETRIES + 1);
    localparam int unsigned REARM_CYCLES = 2;
    localparam int unsigned TMAX_A       = (HOLDOFF_CYCLES > SOFTSTART_CYCLES) ? HOLDOFF_CYCLES : SOFTSTART_CYCLES;
    localparam int unsigned TMAX         = (TMAX_A > REARM_CYCLES) ? TMAX_A : REARM_CYCLES;
    localparam int unsigned TW           = $clog2(TMAX);
    localparam int unsigned SW           = $clog2(STABLE_CYCLES + 1);

    localparam logic [TW-1:0] REARM_LAST = TW'(REARM_CYCLES - 1);
    localparam logic [TW-1:0] SOFT_LAST  = TW'(SOFTSTART_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_REARM     = 3'd0,
        S_SOFTSTART = 3'd1,
        S_RUN       = 3'd2,
        S_DERATE    = 3'd3,
        S_TRIP      = 3'd4,
        S_HOLDOFF   = 3'd5,
        S_LOCKOUT   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] retry_cnt_q, retry_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [SW-1:0] stable_q, stable_d;
    logic          pwr_en_q, pwr_en_d;
    logic          derate_q, derate_d;
    logic          det_rstn_q, det_rstn_d;
    logic          lockout_q, lockout_d;
    logic          trip;
    logic          timed;

    function automatic logic is_run(input state_t s);
        return (s == S_RUN) || (s == S_DERATE);
    endfunction

    assign trip = fault | shutdown;

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            S_REARM: begin
                if (tmr_q == REARM_LAST) state_d = S_SOFTSTART;
            end
            S_SOFTSTART: begin
                if (trip)                   state_d = S_TRIP;
                else if (tmr_q == SOFT_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (trip)         state_d = S_TRIP;
                else if (warning) state_d = S_DERATE;
            end
            S_DERATE: begin
                if (trip)          state_d = S_TRIP;
                else if (!warning) state_d = S_RUN;
            end
            S_TRIP: begin
                if (retry_cnt_q == RETRY_MAX) begin
                    state_d = S_LOCKOUT;
                end else begin
                    state_d     = S_HOLDOFF;
                    retry_cnt_d = retry_cnt_q + RW'(1);
                end
            end
            S_HOLDOFF: begin
                if (tmr_q == HOLD_LAST) state_d = S_REARM;
            end
            S_LOCKOUT: begin
                if (ack_clear) begin
                    state_d     = S_REARM;
                    retry_cnt_d = '0;
                end
            end
            default: state_d = S_REARM;
        endcase

        // The dwell timer restarts on every state change and only runs in the timed states.
        timed = (state_d == state_q) &&
                ((state_q == S_REARM) || (state_q == S_SOFTSTART) || (state_q == S_HOLDOFF));
        tmr_d = timed ? tmr_q + TW'(1) : '0;

        // A clean cycle is one spent in RUN/DERATE that does not end in a trip.
        stable_d = '0;
        if (is_run(state_q) && is_run(state_d)) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
            if ((stable_d == STABLE_MAX) && (stable_q != STABLE_MAX)) retry_cnt_d = '0;
        end

        pwr_en_d   = 1'b0;
        derate_d   = 1'b0;
        det_rstn_d = 1'b1;
        lockout_d  = 1'b0;
        case (state_d)
            S_REARM:     det_rstn_d = 1'b0;
            S_SOFTSTART: begin
                pwr_en_d = 1'b1;
                derate_d = 1'b1;
            end
            S_RUN:       pwr_en_d = 1'b1;
            S_DERATE: begin
                pwr_en_d = 1'b1;
                derate_d = 1'b1;
            end
            S_LOCKOUT:   lockout_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REARM;
            retry_cnt_q <= '0;
            tmr_q       <= '0;
            stable_q    <= '0;
            pwr_en_q    <= 1'b0;
            derate_q    <= 1'b0;
            det_rstn_q  <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            tmr_q       <= tmr_d;
            stable_q    <= stable_d;
            pwr_en_q    <= pwr_en_d;
            derate_q    <= derate_d;
            det_rstn_q  <= det_rstn_d;
            lockout_q   <= lockout_d;
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_cnt_q;
    assign pwr_en    = pwr_en_q;
    assign derate    = derate_q;
    assign det_rstn  = det_rstn_q;
    assign lockout   = lockout_q;

`ifdef FAULT_RESP_TRIP_CNT_EN
    logic [15:0] trip_count_q, trip_count_d;

    always_comb begin
        trip_count_d = trip_count_q;
        if ((state_d == S_TRIP) && (trip_count_q != 16'hFFFF)) trip_count_d = trip_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) trip_count_q <= '0;
        else     trip_count_q <= trip_count_d;
    end

    assign trip_count = trip_count_q;
`endif

endmodule

// File: tb/tb_fault_responder.sv
// Bench for fault_responder: reset/run table, directed retry/lockout/stable-clear/reset sequences,
// and randomized stimulus checked every cycle against a countdown-based reference model.
module tb_fault_responder;

    localparam int HOLDOFF_CYCLES   = 16;
    localparam int MAX_RETRIES      = 3;
    localparam int SOFTSTART_CYCLES = 4;
    localparam int STABLE_CYCLES    = 32;
    localparam int RW               = $clog2(MAX_RETRIES + 1);

    localparam int M_REARM = 0, M_SOFT = 1, M_RUN = 2, M_DER = 3, M_TRIP = 4, M_HOLD = 5, M_LOCK = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          warning = 1'b0;
    logic          fault = 1'b0;
    logic          shutdown = 1'b0;
    logic          ack_clear = 1'b0;
    logic          pwr_en, derate, det_rstn, lockout;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state;
`ifdef FAULT_RESP_TRIP_CNT_EN
    logic [15:0]   trip_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus cycles remaining in it, count of clean run cycles.
    int m_mode  = M_REARM;
    int m_left  = 2;
    int m_clean = 0;
    int m_retry = 0;
    int m_trips = 0;

    fault_responder #(
        .HOLDOFF_CYCLES  (HOLDOFF_CYCLES),
        .MAX_RETRIES     (MAX_RETRIES),
        .SOFTSTART_CYCLES(SOFTSTART_CYCLES),
        .STABLE_CYCLES   (STABLE_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .warning  (warning),
        .fault    (fault),
        .shutdown (shutdown),
        .ack_clear(ack_clear),
        .pwr_en   (pwr_en),
        .derate   (derate),
        .det_rstn (det_rstn),
        .lockout  (lockout),
        .retry_cnt(retry_cnt),
        .state    (state)
`ifdef FAULT_RESP_TRIP_CNT_EN
        ,
        .trip_count(trip_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic enter_trip();
        m_mode  = M_TRIP;
        m_clean = 0;
        if (m_trips < 65535) m_trips++;
    endtask

    task automatic model_step(input logic [4:0] in);
        logic r, w, f, s, a;
        {r, w, f, s, a} = in;
        if (r) begin
            m_mode = M_REARM; m_left = 2; m_clean = 0; m_retry = 0; m_trips = 0;
            return;
        end
        case (m_mode)
            M_REARM: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_SOFT; m_left = SOFTSTART_CYCLES; end
            end
            M_SOFT: begin
                if (f || s) enter_trip();
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_RUN;
                end
            end
            M_RUN, M_DER: begin
                if (f || s) enter_trip();
                else begin
                    if (m_clean < STABLE_CYCLES) begin
                        m_clean++;
                        if (m_clean == STABLE_CYCLES) m_retry = 0;
                    end
                    m_mode = w ? M_DER : M_RUN;
                end
            end
            M_TRIP: begin
                if (m_retry == MAX_RETRIES) m_mode = M_LOCK;
                else begin m_retry++; m_mode = M_HOLD; m_left = HOLDOFF_CYCLES; end
            end
            M_HOLD: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_REARM; m_left = 2; end
            end
            M_LOCK: begin
                if (a) begin m_mode = M_REARM; m_left = 2; m_retry = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        logic [6+RW:0] act, exp;
        logic e_pwr, e_der, e_rstn, e_lock;
        e_pwr  = (m_mode == M_SOFT) || (m_mode == M_RUN) || (m_mode == M_DER);
        e_der  = (m_mode == M_SOFT) || (m_mode == M_DER);
        e_rstn = (m_mode != M_REARM);
        e_lock = (m_mode == M_LOCK);
        exp = {3'(m_mode), e_pwr, e_der, e_rstn, e_lock, RW'(m_retry)};
        act = {state, pwr_en, derate, det_rstn, lockout, retry_cnt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t: got state=%0d pwr=%b der=%b rstn=%b lock=%b retry=%0d, want state=%0d pwr=%b der=%b rstn=%b lock=%b retry=%0d",
                     $time, state, pwr_en, derate, det_rstn, lockout, retry_cnt,
                     m_mode, e_pwr, e_der, e_rstn, e_lock, m_retry);
        end
`ifdef FAULT_RESP_TRIP_CNT_EN
        checks++;
        if (trip_count !== 16'(m_trips)) begin
            errors++;
            $display("FAIL trip_count_cmp t=%0t: got %0d want %0d", $time, trip_count, m_trips);
        end
`endif
    endtask

    task automatic step(input logic [4:0] in);
        {rst, warning, fault, shutdown, ack_clear} = in;
        @(posedge clk);
        model_step(in);
        #1;
        check_model();
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic go_to(input int target, input int budget);
        int n = 0;
        while (m_mode != target && n < budget) begin
            step(5'b00000);
            n++;
        end
        checks++;
        if (m_mode != target) begin
            errors++;
            $display("FAIL go_to: model mode %0d did not reach %0d within %0d cycles", m_mode, target, budget);
        end
    endtask

    task automatic do_reset();
        step(5'b10000);
        step(5'b10000);
    endtask

    task automatic to_lockout();
        for (int k = 1; k <= MAX_RETRIES + 1; k++) begin
            go_to(M_SOFT, 40);
            step(5'b00010);
            step(5'b00000);
        end
    endtask

    typedef struct packed {
        logic [4:0] in;     // {rst, warning, fault, shutdown, ack_clear}
        logic [2:0] st;
        logic [3:0] outs;   // {pwr_en, derate, det_rstn, lockout}
        logic [1:0] retry;
    } vec_t;

    vec_t       tbl [16];
    logic       w_r;
    logic [4:0] rv;

    initial begin
        tbl[0]  = {5'b10000, 3'd0, 4'b0000, 2'd0};
        tbl[1]  = {5'b10000, 3'd0, 4'b0000, 2'd0};
        tbl[2]  = {5'b00000, 3'd0, 4'b0000, 2'd0};
        tbl[3]  = {5'b00000, 3'd1, 4'b1110, 2'd0};
        tbl[4]  = {5'b00000, 3'd1, 4'b1110, 2'd0};
        tbl[5]  = {5'b00000, 3'd1, 4'b1110, 2'd0};
        tbl[6]  = {5'b00000, 3'd1, 4'b1110, 2'd0};
        tbl[7]  = {5'b00000, 3'd2, 4'b1010, 2'd0};
        tbl[8]  = {5'b00000, 3'd2, 4'b1010, 2'd0};
        tbl[9]  = {5'b01000, 3'd3, 4'b1110, 2'd0};
        tbl[10] = {5'b01000, 3'd3, 4'b1110, 2'd0};
        tbl[11] = {5'b01000, 3'd3, 4'b1110, 2'd0};
        tbl[12] = {5'b00000, 3'd2, 4'b1010, 2'd0};
        tbl[13] = {5'b01000, 3'd3, 4'b1110, 2'd0};
        tbl[14] = {5'b01100, 3'd4, 4'b0010, 2'd0};
        tbl[15] = {5'b00000, 3'd5, 4'b0010, 2'd1};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].in);
            $display("vec %0d: in=%b state=%0d pwr_en=%b derate=%b det_rstn=%b lockout=%b retry=%0d",
                     i, tbl[i].in, state, pwr_en, derate, det_rstn, lockout, retry_cnt);
            checks++;
            if ({state, pwr_en, derate, det_rstn, lockout, retry_cnt} !== {tbl[i].st, tbl[i].outs, tbl[i].retry}) begin
                errors++;
                $display("FAIL table_vec %0d: got %b_%b%b%b%b_%b want %b_%b_%b", i, state, pwr_en, derate, det_rstn,
                         lockout, retry_cnt, tbl[i].st, tbl[i].outs, tbl[i].retry);
            end
        end

        // Holdoff runs 16 cycles, then REARM holds det_rstn low for 2 cycles.
        repeat (HOLDOFF_CYCLES - 1) step(5'b00000);
        expect_eq("holdoff_last_cycle", int'(state), M_HOLD);
        step(5'b00000);
        expect_eq("rearm_after_holdoff", int'(det_rstn), 0);
        step(5'b00000);
        expect_eq("rearm_second_cycle", int'(state), M_REARM);
        step(5'b00000);
        expect_eq("softstart_after_rearm", int'(state), M_SOFT);
        $display("seq holdoff/rearm: done, state=%0d retry=%0d", state, retry_cnt);

        // Repeated trips on softstart entry until lockout; ack_clear ignored outside LOCKOUT.
        do_reset();
        for (int k = 1; k <= MAX_RETRIES + 1; k++) begin
            go_to(M_SOFT, 40);
            step(5'b00010);
            expect_eq("trip_entry", int'(state), M_TRIP);
            expect_eq("trip_pwr_off", int'(pwr_en), 0);
            step(5'b00001);
            if (k <= MAX_RETRIES) begin
                expect_eq("retry_increment", int'(retry_cnt), k);
                repeat (3) step(5'b00001);
                expect_eq("ack_in_holdoff_ignored", int'(state), M_HOLD);
            end else begin
                expect_eq("lockout_state", int'(state), M_LOCK);
                expect_eq("lockout_flag", int'(lockout), 1);
            end
        end
        repeat (3) step(5'b00110);
        expect_eq("lockout_holds", int'(lockout), 1);
        step(5'b00001);
        expect_eq("ack_clear_rearm", int'(state), M_REARM);
        expect_eq("ack_clear_retry", int'(retry_cnt), 0);
        $display("seq lockout: done, state=%0d retry=%0d", state, retry_cnt);

        // Stable-run clear after 32 clean cycles, and a trip on the last one.
        do_reset();
        go_to(M_SOFT, 10);
        step(5'b00010);
        go_to(M_SOFT, 40);
        go_to(M_RUN, 10);
        repeat (STABLE_CYCLES - 1) step(5'b00000);
        expect_eq("stable_not_yet", int'(retry_cnt), 1);
        step(5'b00000);
        expect_eq("stable_clear", int'(retry_cnt), 0);
        do_reset();
        go_to(M_SOFT, 10);
        step(5'b00010);
        go_to(M_SOFT, 40);
        go_to(M_RUN, 10);
        repeat (STABLE_CYCLES - 1) step(5'b00000);
        step(5'b00100);
        step(5'b00000);
        expect_eq("trip_at_cycle_31", int'(retry_cnt), 2);
        $display("seq stable: done, retry=%0d", retry_cnt);

        // Reset during HOLDOFF and during LOCKOUT.
        do_reset();
        go_to(M_SOFT, 10);
        step(5'b00010);
        repeat (5) step(5'b00000);
        step(5'b10000);
        expect_eq("rst_in_holdoff_state", int'(state), M_REARM);
        expect_eq("rst_in_holdoff_retry", int'(retry_cnt), 0);
        expect_eq("rst_in_holdoff_rstn", int'(det_rstn), 0);
        step(5'b00000);
        to_lockout();
`ifdef FAULT_RESP_TRIP_CNT_EN
        step(5'b00001);
        expect_eq("trip_count_kept_after_ack", int'(trip_count), MAX_RETRIES + 1);
        to_lockout();
`endif
        expect_eq("pre_rst_lockout", int'(lockout), 1);
        step(5'b10000);
        expect_eq("rst_in_lockout_state", int'(state), M_REARM);
        expect_eq("rst_in_lockout_flag", int'(lockout), 0);
`ifdef FAULT_RESP_TRIP_CNT_EN
        expect_eq("trip_count_after_rst", int'(trip_count), 0);
`endif
        $display("seq reset: done, state=%0d", state);

        // Randomized stimulus against the model.
        do_reset();
        w_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) w_r = ~w_r;
            rv[4] = ($urandom_range(0, 599) == 0);
            rv[3] = w_r;
            rv[2] = ($urandom_range(0, 39) == 0);
            rv[1] = ($urandom_range(0, 69) == 0);
            rv[0] = ($urandom_range(0, 7) == 0);
            step(rv);
        end
        $display("seq random: 3000 cycles done, errors=%0d", errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
